// File: rtl/calc_pkg.sv
// Shared opcode constants and sequencer state encoding for the calculator core.
package calc_pkg;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_DIV = 3'd3;
    localparam logic [2:0] OP_CLR = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ALU      = 3'd1,
        S_MD_START = 3'd2,
        S_MD_WAIT  = 3'd3,
        S_COMMIT   = 3'd4
    } seq_state_e;

    function automatic logic is_md_op(input logic [2:0] code);
        return (code == OP_MUL) || (code == OP_DIV);
    endfunction

    function automatic logic is_alu_op(input logic [2:0] code);
        return (code == OP_ADD) || (code == OP_SUB);
    endfunction

endpackage

// File: rtl/calc_seq_watchdog.sv
// Loadable down-counter guarding the mul/div wait; expired_o is high at terminal count.
module calc_seq_watchdog #(
    parameter int CNT_W = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             expired_o
);

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (en_i && (count_q != '0)) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign expired_o = (count_q == '0);

endmodule

// File: rtl/calc_sequencer.sv
// Calculator operation sequencer: latches operands, dispatches to ALU or mul/div, commits results.
// Optional mul/div watchdog enabled by defining CALC_SEQ_TIMEOUT_EN.
//
// state      | meaning
// -----------+----------------------------------------------------------
// S_IDLE     | ready for a new op; operands latched on accept
// S_ALU      | single-cycle ALU evaluating op_a +/- op_b
// S_MD_START | md_start pulse to the mul/div unit
// S_MD_WAIT  | waiting for md_done (or watchdog expiry when enabled)
// S_COMMIT   | one cycle carrying acc_we / error_flag update
module calc_sequencer
    import calc_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int MD_TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [2:0]       op_code,
    input  logic [WIDTH-1:0] operand_b,
    input  logic [WIDTH-1:0] acc_q,
    output logic [WIDTH-1:0] op_a,
    output logic [WIDTH-1:0] op_b,
    output logic             alu_sub,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_ovf,
    output logic             md_start,
    output logic             md_div,
    input  logic             md_done,
    input  logic [WIDTH-1:0] md_result,
    input  logic             md_err,
    output logic             acc_we,
    output logic [WIDTH-1:0] acc_d,
    output logic             error_flag,
    output logic             busy
);

    localparam int WD_W = $clog2(MD_TIMEOUT + 1);
    // Loaded on entry to S_MD_WAIT so the wait lasts exactly MD_TIMEOUT cycles.
    localparam logic [WD_W-1:0] WD_LOAD = WD_W'(MD_TIMEOUT - 1);

    seq_state_e       state_q;
    logic             op_ready_q;
    logic [WIDTH-1:0] op_a_q;
    logic [WIDTH-1:0] op_b_q;
    logic             alu_sub_q;
    logic             md_start_q;
    logic             md_div_q;
    logic             acc_we_q;
    logic [WIDTH-1:0] acc_d_q;
    logic             error_q;
    logic             wd_expired;

`ifdef CALC_SEQ_TIMEOUT_EN
    calc_seq_watchdog #(
        .CNT_W (WD_W)
    ) u_watchdog (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (state_q == S_MD_START),
        .en_i       (state_q == S_MD_WAIT),
        .load_val_i (WD_LOAD),
        .expired_o  (wd_expired)
    );
`else
    logic [WD_W-1:0] wd_load_unused;
    assign wd_load_unused = WD_LOAD;
    assign wd_expired     = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            op_ready_q <= 1'b1;
            op_a_q     <= '0;
            op_b_q     <= '0;
            alu_sub_q  <= 1'b0;
            md_start_q <= 1'b0;
            md_div_q   <= 1'b0;
            acc_we_q   <= 1'b0;
            acc_d_q    <= '0;
            error_q    <= 1'b0;
        end else begin
            md_start_q <= 1'b0;
            acc_we_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (op_valid) begin
                        op_a_q     <= acc_q;
                        op_b_q     <= operand_b;
                        alu_sub_q  <= (op_code == OP_SUB);
                        md_div_q   <= (op_code == OP_DIV);
                        op_ready_q <= 1'b0;
                        if (is_alu_op(op_code)) begin
                            state_q <= S_ALU;
                        end else if (is_md_op(op_code)) begin
                            state_q    <= S_MD_START;
                            md_start_q <= 1'b1;
                        end else if (op_code == OP_CLR) begin
                            state_q  <= S_COMMIT;
                            acc_we_q <= 1'b1;
                            acc_d_q  <= '0;
                            error_q  <= 1'b0;
                        end else begin
                            state_q <= S_COMMIT;
                            error_q <= 1'b1;
                        end
                    end
                end
                S_ALU: begin
                    state_q <= S_COMMIT;
                    if (alu_ovf) begin
                        error_q <= 1'b1;
                    end else begin
                        acc_we_q <= 1'b1;
                        acc_d_q  <= alu_result;
                        error_q  <= 1'b0;
                    end
                end
                S_MD_START: begin
                    state_q <= S_MD_WAIT;
                end
                S_MD_WAIT: begin
                    if (md_done) begin
                        state_q <= S_COMMIT;
                        if (md_err) begin
                            error_q <= 1'b1;
                        end else begin
                            acc_we_q <= 1'b1;
                            acc_d_q  <= md_result;
                            error_q  <= 1'b0;
                        end
                    end else if (wd_expired) begin
                        state_q <= S_COMMIT;
                        error_q <= 1'b1;
                    end
                end
                S_COMMIT: begin
                    state_q    <= S_IDLE;
                    op_ready_q <= 1'b1;
                end
                default: begin
                    state_q    <= S_IDLE;
                    op_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign op_ready   = op_ready_q;
    assign busy       = ~op_ready_q;
    assign op_a       = op_a_q;
    assign op_b       = op_b_q;
    assign alu_sub    = alu_sub_q;
    assign md_start   = md_start_q;
    assign md_div     = md_div_q;
    assign acc_we     = acc_we_q;
    assign acc_d      = acc_d_q;
    assign error_flag = error_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed self-checking bench for calc_sequencer; ALU and mul/div responses are driven by hand.
module tb_calc_sequencer;

    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             op_valid = 1'b0;
    logic             op_ready;
    logic [2:0]       op_code = 3'd0;
    logic [WIDTH-1:0] operand_b = '0;
    logic [WIDTH-1:0] acc_q = '0;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             alu_sub;
    logic [WIDTH-1:0] alu_result = '0;
    logic             alu_ovf = 1'b0;
    logic             md_start;
    logic             md_div;
    logic             md_done = 1'b0;
    logic [WIDTH-1:0] md_result = '0;
    logic             md_err = 1'b0;
    logic             acc_we;
    logic [WIDTH-1:0] acc_d;
    logic             error_flag;
    logic             busy;

    int n_chk = 0;
    int n_fail = 0;
    int we_cnt = 0;
    int ms_cnt = 0;
    logic prev_we = 1'b0;

    calc_sequencer #(.WIDTH(WIDTH), .MD_TIMEOUT(64)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .op_valid   (op_valid),
        .op_ready   (op_ready),
        .op_code    (op_code),
        .operand_b  (operand_b),
        .acc_q      (acc_q),
        .op_a       (op_a),
        .op_b       (op_b),
        .alu_sub    (alu_sub),
        .alu_result (alu_result),
        .alu_ovf    (alu_ovf),
        .md_start   (md_start),
        .md_div     (md_div),
        .md_done    (md_done),
        .md_result  (md_result),
        .md_err     (md_err),
        .acc_we     (acc_we),
        .acc_d      (acc_d),
        .error_flag (error_flag),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // acc_we must never be high on two consecutive cycles
    always @(negedge clk) begin
        if (acc_we) begin
            we_cnt++;
            chk("we_single_cycle", {31'd0, prev_we}, 32'd0);
        end
        if (md_start) ms_cnt++;
        prev_we = acc_we;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present an op and return 1ns after the accepting edge.
    task automatic issue(input logic [2:0] code, input logic [WIDTH-1:0] b, input bit hold);
        op_code   = code;
        operand_b = b;
        op_valid  = 1'b1;
        for (int i = 0; i < 100 && !op_ready; i++) tick();
        if (!op_ready) chk("ready_wait_timeout", {31'd0, op_ready}, 32'd1);
        tick();
        if (!hold) op_valid = 1'b0;
    endtask

    initial begin
        int we_base;
        int ms_base;
        bit ok;

        #2 rst_n = 1'b0;
        #20;
        chk("rst_op_ready", {31'd0, op_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_acc_we", {31'd0, acc_we}, 32'd0);
        chk("rst_acc_d", {16'd0, acc_d}, 32'd0);
        chk("rst_error", {31'd0, error_flag}, 32'd0);
        chk("rst_md_start", {31'd0, md_start}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // ADD 5 + 3
        acc_q = 16'd5; alu_result = 16'd8; alu_ovf = 1'b0;
        we_base = we_cnt;
        issue(3'd0, 16'd3, 1'b0);
        chk("add_e0_ready", {31'd0, op_ready}, 32'd0);
        chk("add_e0_busy", {31'd0, busy}, 32'd1);
        chk("add_op_a", {16'd0, op_a}, 32'd5);
        chk("add_op_b", {16'd0, op_b}, 32'd3);
        chk("add_alu_sub", {31'd0, alu_sub}, 32'd0);
        chk("add_e0_we", {31'd0, acc_we}, 32'd0);
        tick();
        chk("add_e1_we", {31'd0, acc_we}, 32'd1);
        chk("add_acc_d", {16'd0, acc_d}, 32'd8);
        chk("add_error", {31'd0, error_flag}, 32'd0);
        chk("add_e1_ready", {31'd0, op_ready}, 32'd0);
        tick();
        chk("add_e2_we", {31'd0, acc_we}, 32'd0);
        chk("add_e2_ready", {31'd0, op_ready}, 32'd1);
        chk("add_we_count", we_cnt - we_base, 32'd1);

        // ADD with overflow, then a clean SUB
        alu_result = 16'h7FFF; alu_ovf = 1'b1;
        we_base = we_cnt;
        issue(3'd0, 16'd1, 1'b0);
        tick();
        chk("ovf_we", {31'd0, acc_we}, 32'd0);
        chk("ovf_error", {31'd0, error_flag}, 32'd1);
        repeat (10) tick();
        chk("ovf_error_held", {31'd0, error_flag}, 32'd1);
        chk("ovf_acc_d_kept", {16'd0, acc_d}, 32'd8);
        chk("ovf_we_count", we_cnt - we_base, 32'd0);
        alu_ovf = 1'b0; alu_result = 16'd2;
        issue(3'd1, 16'd3, 1'b0);
        chk("sub_alu_sub", {31'd0, alu_sub}, 32'd1);
        tick();
        chk("sub_we", {31'd0, acc_we}, 32'd1);
        chk("sub_acc_d", {16'd0, acc_d}, 32'd2);
        chk("sub_error_cleared", {31'd0, error_flag}, 32'd0);
        tick();

        // DIV with md_err, md_done 5 cycles after md_start
        we_base = we_cnt; ms_base = ms_cnt;
        issue(3'd3, 16'd0, 1'b0);
        chk("div_md_start", {31'd0, md_start}, 32'd1);
        chk("div_md_div", {31'd0, md_div}, 32'd1);
        tick();
        chk("div_md_start_drop", {31'd0, md_start}, 32'd0);
        repeat (3) tick();
        chk("div_busy_wait", {31'd0, busy}, 32'd1);
        md_done = 1'b1; md_err = 1'b1; md_result = 16'hFFFF;
        tick();
        md_done = 1'b0; md_err = 1'b0;
        chk("div_we", {31'd0, acc_we}, 32'd0);
        chk("div_error", {31'd0, error_flag}, 32'd1);
        chk("div_commit_ready", {31'd0, op_ready}, 32'd0);
        tick();
        chk("div_ready", {31'd0, op_ready}, 32'd1);
        chk("div_md_start_count", ms_cnt - ms_base, 32'd1);
        chk("div_we_count", we_cnt - we_base, 32'd0);

        // MUL with op_valid held, md_done after 40 cycles
        acc_q = 16'd2;
        we_base = we_cnt; ms_base = ms_cnt;
        issue(3'd2, 16'h0600, 1'b1);
        chk("mul_md_start", {31'd0, md_start}, 32'd1);
        chk("mul_md_div", {31'd0, md_div}, 32'd0);
        ok = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (op_ready) ok = 1'b0;
        end
        chk("mul_ready_low", {31'd0, ok}, 32'd1);
        md_done = 1'b1; md_result = 16'h0C00;
        tick();
        md_done = 1'b0;
        chk("mul_we", {31'd0, acc_we}, 32'd1);
        chk("mul_acc_d", {16'd0, acc_d}, 32'h0C00);
        chk("mul_commit_ready", {31'd0, op_ready}, 32'd0);
        chk("mul_no_second_start", ms_cnt - ms_base, 32'd1);
        acc_q = 16'h0C00;
        tick();
        chk("mul_ready_after", {31'd0, op_ready}, 32'd1);
        chk("mul_we_count", we_cnt - we_base, 32'd1);
        tick();
        op_valid = 1'b0;
        chk("mul2_accept_start", {31'd0, md_start}, 32'd1);
        chk("mul2_op_a", {16'd0, op_a}, 32'h0C00);
        tick();

`ifdef CALC_SEQ_TIMEOUT_EN
        repeat (63) tick();
        chk("to_still_waiting", {31'd0, op_ready}, 32'd0);
        chk("to_no_early_error", {31'd0, error_flag}, 32'd0);
        tick();
        chk("to_error", {31'd0, error_flag}, 32'd1);
        chk("to_we", {31'd0, acc_we}, 32'd0);
        tick();
        chk("to_ready", {31'd0, op_ready}, 32'd1);
        md_done = 1'b1; md_result = 16'h5555;
        tick();
        md_done = 1'b0;
        chk("late_done_we", {31'd0, acc_we}, 32'd0);
        chk("late_done_ready", {31'd0, op_ready}, 32'd1);
        chk("late_done_acc_d", {16'd0, acc_d}, 32'h0C00);
        issue(3'd2, 16'd1, 1'b0);
        tick();
`else
        ok = 1'b1;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (!busy) ok = 1'b0;
        end
        chk("no_to_busy_held", {31'd0, ok}, 32'd1);
`endif

        // Reset in MD_WAIT with md_done pending
        md_done = 1'b1; md_result = 16'h1111;
        rst_n = 1'b0;
        #1;
        chk("mrst_op_ready", {31'd0, op_ready}, 32'd1);
        chk("mrst_busy", {31'd0, busy}, 32'd0);
        chk("mrst_acc_d", {16'd0, acc_d}, 32'd0);
        chk("mrst_op_a", {16'd0, op_a}, 32'd0);
        chk("mrst_op_b", {16'd0, op_b}, 32'd0);
        chk("mrst_error", {31'd0, error_flag}, 32'd0);
        chk("mrst_md_div", {31'd0, md_div}, 32'd0);
        chk("mrst_alu_sub", {31'd0, alu_sub}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        md_done = 1'b0;
        chk("mrst_done_ignored_we", {31'd0, acc_we}, 32'd0);
        chk("mrst_done_ignored_ready", {31'd0, op_ready}, 32'd1);

        // Illegal opcode, then CLR
        issue(3'd6, 16'd9, 1'b0);
        chk("ill_we", {31'd0, acc_we}, 32'd0);
        chk("ill_error", {31'd0, error_flag}, 32'd1);
        chk("ill_commit_ready", {31'd0, op_ready}, 32'd0);
        tick();
        chk("ill_ready", {31'd0, op_ready}, 32'd1);
        acc_q = 16'h1234;
        issue(3'd4, 16'h00AA, 1'b0);
        chk("clr_we", {31'd0, acc_we}, 32'd1);
        chk("clr_acc_d", {16'd0, acc_d}, 32'd0);
        chk("clr_error", {31'd0, error_flag}, 32'd0);
        chk("clr_op_a", {16'd0, op_a}, 32'h1234);
        tick();
        chk("clr_ready", {31'd0, op_ready}, 32'd1);
        chk("clr_we_drop", {31'd0, acc_we}, 32'd0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
